// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment scanner.
// Scans NUM_DIGITS BCD digits one slot at a time. Each slot starts with a
// short dark window to suppress ghosting. Inputs are latched once per frame
// into shadow registers, so a frame never tears. Masked digits flash with
// the blink input from the blinker stage.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_driver #(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int DIGIT_REFRESH_RATE_IN_HZ    = 1000,
    parameter int NUM_DIGITS                  = 4,
    parameter int BLANK_CYCLES                = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blink,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int DIGIT_PERIOD = BOARD_CLOCK_FREQUENCY_IN_HZ / DIGIT_REFRESH_RATE_IN_HZ;
    localparam int CNT_W        = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_PERIOD) begin : g_bad_blank
            $error("seg7_scan_driver: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIGIT_PERIOD");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic                    latch_shadow;
    logic                    frame_next;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_mask;
    logic                    sh_blink;

    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_mask;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // BCD to active-low {g,f,e,d,c,b,a}; A..E are blank, F is a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hF:    s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Scan sequencing: idle holds the counters at zero; leaving idle or
    // wrapping past the last digit starts a frame and latches the shadows.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = idx;
        latch_shadow = 1'b0;
        frame_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (enable) begin
                    state_next   = ST_SCAN;
                    latch_shadow = 1'b1;
                    frame_next   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (idx == IDX_LAST) begin
                        idx_next     = '0;
                        latch_shadow = 1'b1;
                        frame_next   = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, slot counter, digit index and frame pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            frame_start <= frame_next;
        end
    end

    // Frame-synchronous snapshot of everything that shapes the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_mask   <= '0;
            sh_blink  <= 1'b0;
        end else if (latch_shadow) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_mask   <= blink_mask;
            sh_blink  <= blink;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // A digit is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        lz_vec   = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run  = zero_run && (sh_digits[4*i +: 4] == 4'd0);
            lz_vec[i] = zero_run;
        end
    end
`else
    assign lz_vec = '0;
`endif

    // Select the current digit's shadow data and build the next output word.
    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_mask = 1'b0;
        cur_lz   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code = sh_digits[4*i +: 4];
                cur_dp   = sh_dp[i];
                cur_mask = sh_mask[i];
                cur_lz   = lz_vec[i];
            end
        end
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (state == ST_SCAN && enable && cnt >= CNT_BLANK &&
            !(cur_mask && sh_blink) && !cur_lz) begin
            an_next  = ~(NUM_DIGITS'(1) << idx);
            seg_next = decode(cur_code);
            dp_next  = ~cur_dp;
        end
    end

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver.
// Stimulus queues the expected frame_start and lit-digit events of each
// frame; a monitor pops and compares them as the display produces them.
module tb_seg7_scan_driver;

    typedef enum logic {
        EV_FRAME,
        EV_LIT
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t   kind;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } ev_t;

    ev_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        enable     = 1'b0;
    logic [15:0] digits_in  = '0;
    logic [3:0]  dp_in      = '0;
    logic        blink      = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    logic [3:0]  prev_an  = 4'hF;
    int          run_len  = 0;

    seg7_scan_driver #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .DIGIT_REFRESH_RATE_IN_HZ(100),
        .NUM_DIGITS(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .blink(blink),
        .blink_mask(blink_mask),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    task automatic checkDark(input string name);
        checkOutput({name, ".an"}, 32'(an), 32'h0000_000F);
        checkOutput({name, ".seg"}, 32'(seg), 32'h0000_007F);
        checkOutput({name, ".dp"}, 32'(dp), 32'h0000_0001);
        checkOutput({name, ".frame_start"}, 32'(frame_start), 32'h0000_0000);
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] m, input logic b);
        digits_in  = d;
        dp_in      = p;
        blink_mask = m;
        blink      = b;
    endtask

    // segs = {seg3, seg2, seg1, seg0}; lit[i] = digit i is expected to light.
    task automatic pushFrame(input logic [27:0] segs, input logic [3:0] dps, input logic [3:0] lit);
        ev_t        e;
        logic [3:0] one;
        one = 4'b0001;
        e = '{kind: EV_FRAME, an: 4'h0, seg: 7'h00, dp: 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            if (lit[i]) begin
                e.kind = EV_LIT;
                e.an   = ~(one << i);
                e.seg  = segs[7*i +: 7];
                e.dp   = ~dps[i];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic popCheck(input ev_t act);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scan_event: got kind=%0d an=%h seg=%h dp=%b, expected no event",
                     act.kind, act.an, act.seg, act.dp);
        end else begin
            e = exp_q.pop_front();
            checkOutput("scan_event{kind,an,seg,dp}", 32'(act), 32'(e));
        end
    endtask

    task automatic waitFrame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) reportTimeout(name);
    endtask

    task automatic waitAn(input logic [3:0] target, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== target && n < 100);
        if (an !== target) reportTimeout(name);
    endtask

    // Monitor: a frame pulse or the start of a new lit run is one event.
    always @(negedge clk) begin
        ev_t act;
        if (rst) begin
            prev_an = 4'hF;
            run_len = 0;
        end else begin
            if (frame_start) begin
                act = '{kind: EV_FRAME, an: 4'h0, seg: 7'h00, dp: 1'b0};
                popCheck(act);
            end
            if (an != 4'hF && an != prev_an) begin
                act = '{kind: EV_LIT, an: an, seg: seg, dp: dp};
                popCheck(act);
            end
            if (an != prev_an && prev_an != 4'hF && enable)
                checkOutput("active_slot_length", 32'(run_len), 32'd8);
            run_len = (an != prev_an) ? 1 : run_len + 1;
            prev_an = an;
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1 checkDark("reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        repeat (3) @(negedge clk);
        checkDark("disabled");

        // Frame 1 shows 1234 with the decimal point on digit 2.
        applyStimulus(16'h1234, 4'b0100, 4'b0000, 1'b0);
        pushFrame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, 4'b1111);
        #2 enable = 1'b1;
        waitFrame("frame1_start");

        // Mid-frame change to 9999 must only appear in frame 2.
        pushFrame({7'h10, 7'h10, 7'h10, 7'h10}, 4'b0100, 4'b1111);
        repeat (15) @(negedge clk);
        applyStimulus(16'h9999, 4'b0100, 4'b0000, 1'b0);
        waitFrame("frame2_start");

        // Blink high with digit 0 masked: digit 0 stays dark.
        applyStimulus(16'h9999, 4'b0100, 4'b0001, 1'b1);
        pushFrame({7'h10, 7'h10, 7'h10, 7'h10}, 4'b0100, 4'b1110);
        waitFrame("frame3_start");

        // Blink low: digit 0 shows again.
        applyStimulus(16'h9999, 4'b0100, 4'b0001, 1'b0);
        pushFrame({7'h10, 7'h10, 7'h10, 7'h10}, 4'b0100, 4'b1111);
        waitFrame("frame4_start");

        // Codes F (dash) and B (blank, anode still driven).
        applyStimulus(16'h12FB, 4'b0000, 4'b0000, 1'b0);
        pushFrame({7'h79, 7'h24, 7'h3F, 7'h7F}, 4'b0000, 4'b1111);
        waitFrame("frame5_start");

        // Leading zeros.
        applyStimulus(16'h0005, 4'b0000, 4'b0000, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
        pushFrame({7'h40, 7'h40, 7'h40, 7'h12}, 4'b0000, 4'b0001);
`else
        pushFrame({7'h40, 7'h40, 7'h40, 7'h12}, 4'b0000, 4'b1111);
`endif
        waitFrame("frame6_start");

        // Async reset while digit 2 is lit.
        applyStimulus(16'h1234, 4'b0100, 4'b0000, 1'b0);
        pushFrame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, 4'b1111);
        waitFrame("frame7_start");
        waitAn(4'hB, "frame7_digit2");
        #2 rst = 1'b1;
        #1 checkDark("async_reset");
        checkOutput("pending_at_reset", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        pushFrame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, 4'b1111);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        waitFrame("restart_frame");

        // One more frame, then drop enable mid-slot on digit 1.
        pushFrame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, 4'b1111);
        waitFrame("frame9_start");
        waitAn(4'hD, "frame9_digit1");
        #2 enable = 1'b0;
        @(negedge clk);
        checkDark("enable_fall");
        checkOutput("pending_at_disable", 32'(exp_q.size()), 32'd2);
        exp_q.delete();

        repeat (60) @(negedge clk);
        checkDark("disabled_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
